// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU codes and the decode/ID-EX bundles.
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnXor   = 6'h26;
    localparam logic [5:0] FnSlt   = 6'h2A;

    typedef enum logic [3:0] {
        AluNop = 4'd0,
        AluAdd = 4'd1,
        AluSub = 4'd2,
        AluAnd = 4'd3,
        AluOr  = 4'd4,
        AluXor = 4'd5,
        AluSlt = 4'd6,
        AluSll = 4'd7,
        AluSrl = 4'd8,
        AluLui = 4'd9
    } alu_op_e;

    // Decoder output: register-file reads plus everything ID/EX captures
    typedef struct packed {
        logic        re1;
        logic        re2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] imm;
        alu_op_e     aluop;
        logic        use_imm;
        logic        we;
        logic [4:0]  wa;
        logic        mem_rd;
        logic        mem_wr;
        logic        invalid;
    } dec_t;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        alu_op_e     aluop;
        logic        use_imm;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
        logic        invalid;
        logic [4:0]  wa;
    } ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS-subset instruction decoder.
module id_decode
    import mips_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sh;
    logic [15:0] w_imm16;

    assign w_op    = i_inst[31:26];
    assign w_rs    = i_inst[25:21];
    assign w_rt    = i_inst[20:16];
    assign w_rd    = i_inst[15:11];
    assign w_sh    = i_inst[10:6];
    assign w_fn    = i_inst[5:0];
    assign w_imm16 = i_inst[15:0];

    // Decode fields and controls; the all-zero word is the canonical NOP, not an SLL.
    always_comb begin
        o_dec = '0;
        if (i_inst != 32'h0) begin
            unique case (w_op)
                OpRtype: begin
                    o_dec.re1 = 1'b1;
                    o_dec.ra1 = w_rs;
                    o_dec.re2 = 1'b1;
                    o_dec.ra2 = w_rt;
                    o_dec.wa  = w_rd;
                    o_dec.we  = 1'b1;
                    unique case (w_fn)
                        FnAddu: o_dec.aluop = AluAdd;
                        FnSubu: o_dec.aluop = AluSub;
                        FnAnd:  o_dec.aluop = AluAnd;
                        FnOr:   o_dec.aluop = AluOr;
                        FnXor:  o_dec.aluop = AluXor;
                        FnSlt:  o_dec.aluop = AluSlt;
                        FnSll, FnSrl: begin
                            o_dec.aluop   = (w_fn == FnSll) ? AluSll : AluSrl;
                            o_dec.re1     = 1'b0;
                            o_dec.ra1     = 5'd0;
                            o_dec.imm     = {27'd0, w_sh};
                            o_dec.use_imm = 1'b1;
                        end
                        default: begin
                            o_dec         = '0;
                            o_dec.invalid = 1'b1;
                        end
                    endcase
                end
                OpAddiu, OpSlti, OpAndi, OpOri, OpXori, OpLw: begin
                    o_dec.re1     = 1'b1;
                    o_dec.ra1     = w_rs;
                    o_dec.use_imm = 1'b1;
                    o_dec.wa      = w_rt;
                    o_dec.we      = 1'b1;
                    unique case (w_op)
                        OpAddiu: o_dec.aluop = AluAdd;
                        OpSlti:  o_dec.aluop = AluSlt;
                        OpAndi:  o_dec.aluop = AluAnd;
                        OpOri:   o_dec.aluop = AluOr;
                        OpXori:  o_dec.aluop = AluXor;
                        default: o_dec.aluop = AluAdd;
                    endcase
                    o_dec.mem_rd = (w_op == OpLw);
                    // Logical immediates are zero-extended, arithmetic/address ones signed
                    if (w_op == OpAndi || w_op == OpOri || w_op == OpXori) begin
                        o_dec.imm = {16'h0, w_imm16};
                    end else begin
                        o_dec.imm = sext16(w_imm16);
                    end
                end
                OpLui: begin
                    o_dec.aluop   = AluLui;
                    o_dec.imm     = {w_imm16, 16'h0};
                    o_dec.use_imm = 1'b1;
                    o_dec.wa      = w_rt;
                    o_dec.we      = 1'b1;
                end
                OpSw: begin
                    o_dec.re1     = 1'b1;
                    o_dec.ra1     = w_rs;
                    o_dec.re2     = 1'b1;
                    o_dec.ra2     = w_rt;
                    o_dec.aluop   = AluAdd;
                    o_dec.imm     = sext16(w_imm16);
                    o_dec.use_imm = 1'b1;
                    o_dec.mem_wr  = 1'b1;
                end
                default: begin
                    o_dec.invalid = 1'b1;
                end
            endcase
        end
        // Writes to $0 are architecturally discarded
        if (o_dec.wa == 5'd0) begin
            o_dec.we = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decoder, operand forwarding, load-use hazard, ID/EX register.
module id_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        re1,
    output logic        re2,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic        fw_ex_we,
    input  logic [4:0]  fw_ex_wa,
    input  logic [31:0] fw_ex_wd,
    input  logic        fw_ex_load,
    input  logic        fw_mem_we,
    input  logic [4:0]  fw_mem_wa,
    input  logic [31:0] fw_mem_wd,
    output logic        id_stall_req,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_reg1,
    output logic [31:0] ex_reg2,
    output logic [31:0] ex_imm,
    output logic [3:0]  ex_aluop,
    output logic        ex_use_imm,
    output logic        ex_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_invalid,
    output logic [4:0]  ex_wa
);

    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    dec_t        w_dec;
    ex_t         r_ex;
    ex_t         w_ex_d;
    logic        w_hold_if;
    logic        w_bubble;

    id_decode u_decode (
        .i_inst (r_if_inst),
        .o_dec  (w_dec)
    );

    assign re1 = w_dec.re1;
    assign re2 = w_dec.re2;
    assign ra1 = w_dec.ra1;
    assign ra2 = w_dec.ra2;

    // Operand select: $0, then the younger EX result, then MEM, then register file
    function automatic logic [31:0] fwd_sel(
        input logic        en,
        input logic [4:0]  addr,
        input logic [31:0] rf,
        input logic        ex_we_i,
        input logic [4:0]  ex_wa_i,
        input logic [31:0] ex_wd_i,
        input logic        mem_we_i,
        input logic [4:0]  mem_wa_i,
        input logic [31:0] mem_wd_i
    );
        if (!en || addr == 5'd0)                 return 32'h0;
        else if (ex_we_i && ex_wa_i == addr)     return ex_wd_i;
        else if (mem_we_i && mem_wa_i == addr)   return mem_wd_i;
        else                                     return rf;
    endfunction

    // Load-use hazard: a load in EX cannot forward its data in time
    always_comb begin
        id_stall_req = fw_ex_load && fw_ex_we && (fw_ex_wa != 5'd0) &&
                       ((re1 && ra1 == fw_ex_wa) || (re2 && ra2 == fw_ex_wa));
    end

    assign w_hold_if = stall | id_stall_req;
    assign w_bubble  = flush | stall | id_stall_req;

    // Assemble the next ID/EX contents from decode and forwarded operands
    always_comb begin
        w_ex_d         = '0;
        w_ex_d.pc      = r_if_pc;
        w_ex_d.reg1    = fwd_sel(w_dec.re1, w_dec.ra1, rd1, fw_ex_we, fw_ex_wa, fw_ex_wd,
                                 fw_mem_we, fw_mem_wa, fw_mem_wd);
        w_ex_d.reg2    = fwd_sel(w_dec.re2, w_dec.ra2, rd2, fw_ex_we, fw_ex_wa, fw_ex_wd,
                                 fw_mem_we, fw_mem_wa, fw_mem_wd);
        w_ex_d.imm     = w_dec.imm;
        w_ex_d.aluop   = w_dec.aluop;
        w_ex_d.use_imm = w_dec.use_imm;
        w_ex_d.we      = w_dec.we;
        w_ex_d.mem_rd  = w_dec.mem_rd;
        w_ex_d.mem_wr  = w_dec.mem_wr;
        w_ex_d.invalid = w_dec.invalid;
        w_ex_d.wa      = w_dec.wa;
    end

    // IF/ID register: flush injects a NOP and wins over any hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_pc   <= 32'h0;
            r_if_inst <= 32'h0;
        end else if (flush) begin
            r_if_pc   <= 32'h0;
            r_if_inst <= 32'h0;
        end else if (!w_hold_if) begin
            r_if_pc   <= if_pc;
            r_if_inst <= if_inst;
        end
    end

    // ID/EX register: any stall or flush sends an all-zero bubble downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
        end else if (w_bubble) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_ex_d;
        end
    end

    assign ex_pc      = r_ex.pc;
    assign ex_reg1    = r_ex.reg1;
    assign ex_reg2    = r_ex.reg2;
    assign ex_imm     = r_ex.imm;
    assign ex_aluop   = r_ex.aluop;
    assign ex_use_imm = r_ex.use_imm;
    assign ex_we      = r_ex.we;
    assign ex_mem_rd  = r_ex.mem_rd;
    assign ex_mem_wr  = r_ex.mem_wr;
    assign ex_invalid = r_ex.invalid;
    assign ex_wa      = r_ex.wa;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 stall  input  1  global stall from pipeline control; hold IF/ID, bubble ID/EX.
REQ-004 flush  input  1  global flush; overrides stall.
REQ-005 if_pc, if_inst  input  32 each  fetched PC and instruction from IF.
REQ-006 re1, re2  output  1 each  register-file read enables.
REQ-007 ra1, ra2  output  5 each  register-file read addresses (rs, rt).
REQ-008 rd1, rd2  input  32 each  register-file read data; WB-to-ID bypass already inside register file.
REQ-009 fw_ex_we, fw_ex_wa, fw_ex_wd, fw_ex_load  input  1/5/32/1  EX-stage result for forwarding; fw_ex_load marks a load.
REQ-010 fw_mem_we, fw_mem_wa, fw_mem_wd  input  1/5/32  MEM-stage result for forwarding.
REQ-011 id_stall_req  output  1  combinational load-use stall request.
REQ-012 ex_pc, ex_reg1, ex_reg2, ex_imm  output  32 each  registered operands to EX.
REQ-013 ex_aluop  output  4  registered ALU operation code.
REQ-014 ex_use_imm, ex_we, ex_mem_rd, ex_mem_wr, ex_invalid  output  1 each  registered controls.
REQ-015 ex_wa  output  5  registered destination register.

Function
REQ-016 IF/ID register SHALL capture if_pc/if_inst each edge unless stall or id_stall_req; flush SHALL load inst 0 (NOP).
REQ-017 Decode SHALL support ADDU SUBU AND OR XOR SLT SLL SRL (R-type), ADDIU SLTI ANDI ORI XORI LUI, LW, SW; all else SHALL decode as NOP with ex_invalid=1.
REQ-018 re1=1 with ra1=rs when rs used; re2=1 with ra2=rt for R-type (except SLL/SRL re1=0) and SW; unused enables 0, addresses 0.
REQ-019 Immediate: sign-extended for ADDIU SLTI LW SW; zero-extended for ANDI ORI XORI; LUI -> {imm16,16'h0}; SLL/SRL -> zero-extended shamt placed in ex_imm with ex_use_imm=1.
REQ-020 Destination: rd for R-type, rt for I-type/LW; SW and NOP ex_we=0; destination 0 SHALL force ex_we=0.
REQ-021 Operand select per port, priority: address 0 -> 0; EX match (fw_ex_we, fw_ex_wa==addr) -> fw_ex_wd; MEM match -> fw_mem_wd; else rd1/rd2; disabled port -> 0.
REQ-022 id_stall_req=1 iff fw_ex_load & fw_ex_we & fw_ex_wa!=0 & ((re1 & ra1==fw_ex_wa) | (re2 & ra2==fw_ex_wa)).
REQ-023 ID/EX register: flush, stall or id_stall_req SHALL load a bubble (all outputs 0); otherwise capture decoded values; latency one cycle ID-in to EX-out.
REQ-024 ALU codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, XOR 5, SLT 6, SLL 7, SRL 8, LUI 9; LW/SW use ADD.

Reset
REQ-025 rst asserted SHALL clear IF/ID (pc 0, inst 0) and every ex_* output to 0 immediately, independent of clk.
REQ-026 Reset mid-stall SHALL discard the held instruction; first post-reset edge captures if_inst normally.

Structure
REQ-027 Opcode/funct constants and ALU code constants SHALL live in shared package mips_pkg.
REQ-028 Combinational decoder SHALL be sub-module id_decode; pipeline registers, forwarding mux and hazard logic stay in id_stage.

Verification
REQ-029 ADDU $3,$1,$2 with rd1=5, rd2=7, no forwarding -> next cycle ex_aluop=1, ex_reg1=5, ex_reg2=7, ex_wa=3, ex_we=1.
REQ-030 ORI $4,$0,0xFFFF -> ex_imm=32'h0000FFFF, ex_reg1=0, ex_use_imm=1; ADDIU $4,$0,0xFFFF -> ex_imm=32'hFFFFFFFF.
REQ-031 rs=$5, fw_ex_wa=5 wd=0xAA, fw_mem_wa=5 wd=0xBB, rd1=0xCC -> ex_reg1=0xAA; EX disabled -> 0xBB.
REQ-032 LW $6 in EX (fw_ex_load=1) and ID holds ADDU $7,$6,$1 -> id_stall_req=1, IF/ID held, ID/EX bubble, ex_we=0.
REQ-033 flush with stall both asserted -> IF/ID inst 0, ID/EX bubble; opcode 6'h3F -> ex_invalid=1, ex_we=0.
REQ-034 rst pulsed mid-stream between edges -> all ex_* 0 immediately, before next clk edge.
